// File: rtl/icache_ro.sv
// icache_ro: read-only direct-mapped instruction cache, 4-word lines, NUM_BLOCKS lines.
// Hits return data in the same cycle. A miss stalls the fetch side for the memory latency plus one cycle.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache_ro #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t                 r_state;
  logic                   r_mem_read;
  logic [27:0]            r_miss_addr;
  logic [NUM_BLOCKS-1:0]  r_valid;
  logic [TAG_W-1:0]       r_tag  [NUM_BLOCKS];
  logic [127:0]           r_data [NUM_BLOCKS];

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [IDX_W-1:0]       w_fill_idx;
  logic [127:0]           w_line;
  logic                   w_hit;
  logic                   w_fill;
  logic                   w_unused;

  // Address fields of the current request and of the outstanding miss.
  assign w_idx      = proc_addr[IDX_W+1:2];
  assign w_tag      = proc_addr[29:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W-1:0];

  // Writes are not supported; their data and strobe are deliberately dropped.
  assign w_unused = ^{proc_write, proc_wdata};

  assign w_hit  = proc_read && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line = r_data[w_idx];

  // Word select is unconditional; the requester qualifies it with !proc_stall.
  assign proc_rdata = w_line[{proc_addr[1:0], 5'b00000} +: 32];

  // The refill cycle itself still stalls; the hit is seen in the following idle cycle.
  assign proc_stall = (r_state == S_FETCH) || (proc_read && !w_hit);

  // A mem_ready pulse coinciding with reset must not fill a line.
  assign w_fill = (r_state == S_FETCH) && mem_ready && !rst;

  assign mem_read  = r_mem_read;
  assign mem_write = 1'b0;
  assign mem_addr  = r_miss_addr;
  assign mem_wdata = '0;

  // Control FSM: launches a line read on a miss and waits for the memory pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_read  <= 1'b0;
      r_miss_addr <= '0;
      r_valid     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (proc_read && !w_hit) begin
            r_miss_addr <= proc_addr[29:2];
            r_mem_read  <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_mem_read          <= 1'b0;
            r_state             <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Line data and tag storage; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fill_idx] <= mem_rdata;
      r_tag[w_fill_idx]  <= r_miss_addr[27:IDX_W];
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Hits count only in idle cycles; a miss counts once when the refill starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (proc_read && !w_hit) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
